// File: rtl/ifetch_pkg.sv
// ifetch_pkg: fetch state encoding, word-offset width and instruction-buffer entry type
package ifetch_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, MISS_WAIT = 2'd1, MISS_FLUSH = 2'd2} state_t;
  localparam int OFFSET_BITS = 2;
  localparam int ENTRY_AW = 32;
  localparam int ENTRY_DW = 32;
  typedef struct packed {
    logic [ENTRY_AW-1:0] pc;
    logic [ENTRY_DW-1:0] data;
  } entry_t;
endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous FIFO with flush and occupancy count; reads back zero when empty
module ifetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata,
  output logic                    valid,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic do_pop;
  assign valid = count != '0;
  assign do_pop = pop & valid;
  assign rdata = valid ? mem[rptr] : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= push ? wptr + PW'(1) : wptr;
      rptr <= do_pop ? rptr + PW'(1) : rptr;
      count <= count + (PW+1)'(push) - (PW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) begin
      mem[wptr] <= wdata;
      assert (count != (PW+1)'(DEPTH));
    end
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: sequential fetch into the icache with miss tracking, redirect flush and a decode buffer
module ifetch_unit import ifetch_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  cache_req,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  input  logic [DATA_WIDTH-1:0] cache_data,
  input  logic                  cache_valid,
  input  logic                  cache_stall,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] pc, pc_nx, pc_inc, resp_pc, push_pc;
  logic inflight, accept, push, pop, unused_ok;
  logic [CW-1:0] occ;
  entry_t wr, rd;
  assign unused_ok = ^redirect_pc[OFFSET_BITS-1:0];
  assign pc_inc = pc + ADDR_WIDTH'(4);
  assign cache_addr = pc;
  // credit counts the hit still in flight so a full buffer never gets pushed
  assign cache_req = state == RUN && !redirect_valid &&
                     ({1'b0, occ} + (CW+1)'(inflight)) < (CW+1)'(FIFO_DEPTH);
  assign accept = cache_req & ~cache_stall;
  assign pop = instr_valid & instr_ready;
  always_comb begin
    state_nx = state;
    pc_nx = pc;
    push = 1'b0;
    push_pc = resp_pc;
    if (redirect_valid) begin
      pc_nx = {redirect_pc[ADDR_WIDTH-1:OFFSET_BITS], OFFSET_BITS'(0)};
      // a miss response landing with the redirect is consumed, so nothing is left to flush
      state_nx = (state == RUN || cache_valid) ? RUN : MISS_FLUSH;
    end else if (state == RUN) begin
      push = inflight & cache_valid;
      pc_nx = accept ? pc_inc : pc;
      state_nx = (cache_req & cache_stall) ? MISS_WAIT : RUN;
    end else if (cache_valid) begin
      push = state == MISS_WAIT;
      push_pc = pc;
      pc_nx = state == MISS_WAIT ? pc_inc : pc;
      state_nx = RUN;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RUN;
      pc <= RESET_PC;
      resp_pc <= '0;
      inflight <= 1'b0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      inflight <= accept;
      resp_pc <= accept ? pc : resp_pc;
    end
  assign wr = {ENTRY_AW'(push_pc), ENTRY_DW'(cache_data)};
  assign instr_pc = rd.pc[ADDR_WIDTH-1:0];
  assign instr_data = rd.data[DATA_WIDTH-1:0];
  ifetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(entry_t))) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(redirect_valid),
    .push(push),
    .pop(pop),
    .wdata(wr),
    .rdata(rd),
    .valid(instr_valid),
    .count(occ)
  );
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: icache model with miss injection, pop scoreboard, cycle vector table and corner sequences
module tb_ifetch_unit;
  logic clk = 1'b0;
  logic rst, redirect_valid, instr_ready;
  logic [31:0] redirect_pc;
  logic cache_req, cache_valid, cache_stall, instr_valid;
  logic [31:0] cache_addr, cache_data, instr_data, instr_pc;
  logic miss_armed, busy, kill;
  logic [31:0] miss_addr, busy_addr;
  int miss_wait, wcnt;
  int checks = 0, fails = 0;
  typedef struct packed { logic [31:0] pc; logic [31:0] data; } exp_t;
  exp_t q[$];
  exp_t mon_e;
  typedef struct { logic ready; logic req; logic [31:0] addr; logic iv; logic [31:0] ipc; } vec_t;
  vec_t tab[11];

  ifetch_unit dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .cache_req(cache_req), .cache_addr(cache_addr), .cache_data(cache_data),
    .cache_valid(cache_valid), .cache_stall(cache_stall), .instr_valid(instr_valid),
    .instr_data(instr_data), .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // cache model: one-cycle hits, a single armed miss address with a configurable wait
  assign cache_stall = cache_req && miss_armed && cache_addr == miss_addr && !busy;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_valid <= 1'b0;
      cache_data <= '0;
      busy <= 1'b0;
      kill = 1'b0;
    end else begin
      cache_valid <= 1'b0;
      if (busy) begin
        if (wcnt == 0) begin
          cache_valid <= 1'b1;
          cache_data <= data_of(busy_addr);
          busy <= 1'b0;
          if (kill) kill = 1'b0;
          else q.push_back({busy_addr, data_of(busy_addr)});
        end else wcnt <= wcnt - 1;
      end else if (cache_stall) begin
        busy <= 1'b1;
        busy_addr <= cache_addr;
        wcnt <= miss_wait;
      end else if (cache_req) begin
        cache_valid <= 1'b1;
        cache_data <= data_of(cache_addr);
        q.push_back({cache_addr, data_of(cache_addr)});
      end
    end
  end

  always @(negedge clk)
    if (rst === 1'b0 && instr_valid && instr_ready) begin
      chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        chk("sb_instr_pc", instr_pc, mon_e.pc);
        chk("sb_instr_data", instr_data, mon_e.data);
      end
    end

  task automatic wait_miss();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      found = cache_req && cache_stall;
      tick();
    end
    chk("miss_seen", 32'(found), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    tab[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    tab[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    tab[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    tab[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    tab[4]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    tab[5]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h0C};
    tab[6]  = '{1'b1, 1'b0, 32'h10, 1'b0, 32'h00};
    tab[7]  = '{1'b1, 1'b0, 32'h10, 1'b0, 32'h00};
    tab[8]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h10};
    tab[9]  = '{1'b1, 1'b1, 32'h18, 1'b0, 32'h00};
    tab[10] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h14};
    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b1;
    miss_armed = 1'b1;
    miss_addr = 32'h10;
    miss_wait = 1;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr_data", instr_data, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_cache_addr", cache_addr, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    // hit stream then a miss at 0x10
    for (int i = 0; i < 11; i++) begin
      instr_ready = tab[i].ready;
      @(negedge clk);
      chk($sformatf("tab%0d_req", i), 32'(cache_req), 32'(tab[i].req));
      chk($sformatf("tab%0d_addr", i), cache_addr, tab[i].addr);
      chk($sformatf("tab%0d_ivalid", i), 32'(instr_valid), 32'(tab[i].iv));
      if (tab[i].iv) chk($sformatf("tab%0d_ipc", i), instr_pc, tab[i].ipc);
      tick();
    end
    miss_armed = 1'b0;
    // backpressure: decode stalled, buffer fills to depth
    instr_ready = 1'b0;
    rst = 1'b1;
    q.delete();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_fill_req", 32'(cache_req), 32'd1);
      chk("bp_fill_addr", cache_addr, 32'(i * 4));
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_full_req", 32'(cache_req), 32'd0);
      chk("bp_full_ivalid", 32'(instr_valid), 32'd1);
      chk("bp_full_ipc", instr_pc, 32'h0);
      tick();
    end
    instr_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_req", 32'(cache_req), 32'd0);
    tick();
    @(negedge clk);
    chk("bp_resume_req", 32'(cache_req), 32'd1);
    chk("bp_resume_addr", cache_addr, 32'h10);
    repeat (6) tick();
    // redirect to 0x103 with a hit in flight
    instr_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    q.delete();
    @(negedge clk);
    chk("rd_req_low", 32'(cache_req), 32'd0);
    tick();
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    chk("rd_req", 32'(cache_req), 32'd1);
    chk("rd_addr", cache_addr, 32'h100);
    chk("rd_flushed", 32'(instr_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("rd_empty2", 32'(instr_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("rd_first_valid", 32'(instr_valid), 32'd1);
    chk("rd_first_pc", instr_pc, 32'h100);
    tick();
    // redirect to 0x200 while waiting on a miss at 0x120
    miss_addr = 32'h120;
    miss_wait = 2;
    miss_armed = 1'b1;
    wait_miss();
    instr_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    q.delete();
    kill = busy;
    miss_armed = 1'b0;
    @(negedge clk);
    chk("mf_req_low", 32'(cache_req), 32'd0);
    tick();
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    begin
      logic got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        got = cache_valid;
        chk("mf_wait_req", 32'(cache_req), 32'd0);
        chk("mf_wait_ivalid", 32'(instr_valid), 32'd0);
        if (!got) tick();
      end
      chk("mf_resp_seen", 32'(got), 32'd1);
    end
    tick();
    @(negedge clk);
    chk("mf_req", 32'(cache_req), 32'd1);
    chk("mf_addr", cache_addr, 32'h200);
    chk("mf_ivalid", 32'(instr_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("mf_ivalid2", 32'(instr_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("mf_first_valid", 32'(instr_valid), 32'd1);
    chk("mf_first_pc", instr_pc, 32'h200);
    tick();
    // reset during a miss wait
    miss_addr = 32'h220;
    miss_wait = 3;
    miss_armed = 1'b1;
    wait_miss();
    rst = 1'b1;
    q.delete();
    miss_armed = 1'b0;
    @(negedge clk);
    chk("mr_rst_ivalid", 32'(instr_valid), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mr_req", 32'(cache_req), 32'd1);
    chk("mr_addr", cache_addr, 32'h0);
    chk("mr_ivalid", 32'(instr_valid), 32'd0);
    tick();
    repeat (8) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
